// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_pkg
//  Brief    : Shared FSM state encoding and default word length.
//  Revision : 1.0
// ============================================================================
package sipo_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_bit_counter
//  Brief    : Received-bit counter with load-1, increment and clear.
//  Revision : 1.0
// ============================================================================
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic load_one,
   input  logic incr,
   input  logic clr,
   output logic at_last
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0] count_d;
   logic [CW-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load_one) begin
         count_d = CW'(1);
      end else if (incr) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The next incremented bit is the WIDTH-th one; the count is cleared
   // on that edge instead, so it never exceeds WIDTH.
   assign at_last = (count_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_deserializer
//  Brief    : MSB-first serial-to-parallel converter with sync framing,
//             one-word output buffer and sticky overrun/frame error flags.
//  Revision : 1.0
// ============================================================================
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             sync,
   input  logic             data_ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   state_t             state_d, state_q;
   logic [WIDTH-1:0]   shift_d, shift_q;
   logic [WIDTH-1:0]   data_d, data_q;
   logic               valid_d, valid_q;
   logic               ovr_d, ovr_q;
   logic               fe_d, fe_q;
   logic               cnt_load, cnt_inc, cnt_clr, cnt_at_last;
   logic               word_done;
   logic [WIDTH-1:0]   shifted;

   assign shifted = {shift_q[WIDTH-2:0], serial_in};

   sipo_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .load_one (cnt_load),
      .incr     (cnt_inc),
      .clr      (cnt_clr),
      .at_last  (cnt_at_last)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      fe_d      = fe_q;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      word_done = 1'b0;

      // Clears are applied first so that a coinciding set event wins.
      if (clr_err) begin
         ovr_d = 1'b0;
         fe_d  = 1'b0;
      end
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (shift_en && sync) begin
               shift_d  = {{(WIDTH-1){1'b0}}, serial_in};
               cnt_load = 1'b1;
               state_d  = RECV;
            end
         end
         RECV: begin
            if (shift_en) begin
               if (sync) begin
                  shift_d  = {{(WIDTH-1){1'b0}}, serial_in};
                  cnt_load = 1'b1;
                  fe_d     = 1'b1;
               end else if (cnt_at_last) begin
                  shift_d   = shifted;
                  cnt_clr   = 1'b1;
                  word_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  shift_d = shifted;
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A completed word only lands if the buffer is empty or draining now.
      if (word_done) begin
         if (!valid_q || data_ready) begin
            data_d  = shifted;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         fe_q    <= fe_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q == RECV);
   assign overrun    = ovr_q;
   assign frame_err  = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_deserializer
//  Brief    : Directed and random stimulus against a word-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_sipo_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         serial_in;
   logic         shift_en;
   logic         sync;
   logic         data_ready;
   logic         clr_err;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         overrun;
   logic         frame_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a word being collected plus a one-entry output buffer.
   int unsigned  m_word;
   int           m_cnt;
   bit           m_recv;
   logic [W-1:0] m_data;
   bit           m_valid;
   bit           m_ovr;
   bit           m_fe;

   always #5 clk = ~clk;

   sipo_deserializer #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .shift_en   (shift_en),
      .sync       (sync),
      .data_ready (data_ready),
      .clr_err    (clr_err),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_word  = 0;
      m_cnt   = 0;
      m_recv  = 0;
      m_data  = '0;
      m_valid = 0;
      m_ovr   = 0;
      m_fe    = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"},  32'(data_out),   32'(m_data));
      chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
      chk({tag, ".busy"},  32'(busy),       32'(m_recv));
      chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
      chk({tag, ".fe"},    32'(frame_err),  32'(m_fe));
   endtask

   // One clock: drive inputs, advance the model with the same inputs, compare.
   task automatic cyc(input bit se, input bit sin, input bit sy, input bit rdy,
                      input bit clr, input string tag);
      bit done    = 0;
      bit ovr_set = 0;
      bit fe_set  = 0;
      bit v_pre;
      shift_en   = se;
      serial_in  = sin;
      sync       = sy;
      data_ready = rdy;
      clr_err    = clr;
      @(posedge clk);
      v_pre = m_valid;
      if (v_pre && rdy) m_valid = 0;
      if (se) begin
         if (sy) begin
            if (m_recv) fe_set = 1;
            m_recv = 1;
            m_word = 32'(sin);
            m_cnt  = 1;
         end else if (m_recv) begin
            m_word = (m_word << 1) | 32'(sin);
            m_cnt++;
            if (m_cnt == W) begin
               done   = 1;
               m_recv = 0;
               m_cnt  = 0;
            end
         end
      end
      if (done) begin
         if (!v_pre || rdy) begin
            m_data  = W'(m_word);
            m_valid = 1;
         end else begin
            ovr_set = 1;
         end
      end
      m_ovr = (clr ? 1'b0 : m_ovr) | ovr_set;
      m_fe  = (clr ? 1'b0 : m_fe)  | fe_set;
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input logic [W-1:0] val, input bit rdy, input bit gaps,
                            input string tag);
      for (int i = W - 1; i >= 0; i--) begin
         cyc(1'b1, val[i], i == W - 1, rdy, 1'b0, tag);
         if (gaps) cyc(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0, tag);
      end
   endtask

   task automatic async_reset(input int hold, input string tag);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      for (int i = 0; i < hold; i++) begin
         shift_en  = 1'($urandom);
         serial_in = 1'($urandom);
         sync      = 1'($urandom);
         @(posedge clk);
         #1;
         check_all(tag);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [W-1:0] piso;
      reset      = 1'b0;
      serial_in  = 1'b0;
      shift_en   = 1'b0;
      sync       = 1'b0;
      data_ready = 1'b0;
      clr_err    = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // Back-to-back bits, consumer always ready
      send_word(8'hA5, 1'b1, 1'b0, "a5");
      chk("a5_data", 32'(data_out), 32'h0000_00A5);
      chk("a5_valid", 32'(data_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "a5_drain");
      chk("a5_valid_once", 32'(data_valid), 32'd0);

      // One idle cycle after every bit
      send_word(8'h3C, 1'b1, 1'b1, "3c");
      chk("3c_data", 32'(data_out), 32'h0000_003C);

      // Consumer stalled: second word is dropped
      send_word(8'h11, 1'b0, 1'b0, "ovr1");
      send_word(8'h22, 1'b0, 1'b0, "ovr2");
      chk("ovr_data", 32'(data_out), 32'h0000_0011);
      chk("ovr_flag", 32'(overrun), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
      chk("ovr_cleared", 32'(overrun), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovr_drain");

      // Sync arriving after four bits of a word
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), i == 0, 1'b1, 1'b0, "fe_part");
      send_word(8'hF0, 1'b1, 1'b0, "fe_word");
      chk("fe_flag", 32'(frame_err), 32'd1);
      chk("fe_data", 32'(data_out), 32'h0000_00F0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fe_clr");

      // Reset in the middle of a word; unsynced bits afterwards are ignored
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), i == 0, 1'b1, 1'b0, "rst_part");
      async_reset(2, "rst_mid");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rst_nosync");
      send_word(8'h81, 1'b1, 1'b0, "rst_81");
      chk("rst_81_data", 32'(data_out), 32'h0000_0081);

      // Upstream PISO: load pulse doubles as sync, shifts MSB first
      piso = 8'h5A;
      for (int i = 0; i < W; i++) begin
         cyc(1'b1, piso[W-1], i == 0, 1'b1, 1'b0, "piso");
         piso = {piso[W-2:0], 1'b0};
      end
      chk("piso_data", 32'(data_out), 32'h0000_005A);

      // Random traffic with occasional resyncs, stalls and clears
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 12) == 0,
             ($urandom % 4) != 0, ($urandom % 40) == 0, "rand");
         if (($urandom % 700) == 0) async_reset(1, "rand_rst");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
